// File: rtl/seg7_if.sv
// Bundle of data-in and display-pin signals between result logic and the
// seven-segment scan driver.
interface seg7_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic [DIGITS-1:0]   dp_in;
   logic                lz_blank;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_tick;

   modport master (
      output value, load, dp_in, lz_blank,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  value, load, dp_in, lz_blank,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: shadow-latched hex value,
// programmable refresh divider, leading-zero blanking and anti-ghost blanking.
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic   clk,
   input  logic   reset,
   seg7_if.slave  bus
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]    div_cnt_r;
   logic [IDX_W-1:0]    digit_idx_r;
   logic [4*DIGITS-1:0] shadow_value_r;
   logic [DIGITS-1:0]   shadow_dp_r;

   logic [6:0]          seg_r;
   logic                dp_r;
   logic [DIGITS-1:0]   an_r;
   logic                frame_tick_r;

   logic [6:0]          seg_s;
   logic                dp_s;
   logic [DIGITS-1:0]   an_s;
   logic                frame_tick_s;
   logic [3:0]          nibble_s;
   logic [DIGITS-1:0]   blank_s;
   logic                zero_run_s;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b0000001;
         4'h1:    pat = 7'b1001111;
         4'h2:    pat = 7'b0010010;
         4'h3:    pat = 7'b0000110;
         4'h4:    pat = 7'b1001100;
         4'h5:    pat = 7'b0100100;
         4'h6:    pat = 7'b0100000;
         4'h7:    pat = 7'b0001111;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0000100;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b1100000;
         4'hC:    pat = 7'b0110001;
         4'hD:    pat = 7'b1000010;
         4'hE:    pat = 7'b0110000;
         4'hF:    pat = 7'b0111000;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   // Refresh divider and digit pointer; the pointer only moves at the end of a slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_r   <= '0;
         digit_idx_r <= '0;
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_r   <= '0;
         digit_idx_r <= (digit_idx_r == DIGIT_LAST) ? '0 : digit_idx_r + IDX_W'(1);
      end else begin
         div_cnt_r   <= div_cnt_r + CNT_W'(1);
      end
   end

   // Shadow copy of the displayed data, updated only on the load strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_value_r <= '0;
         shadow_dp_r    <= '0;
      end else if (bus.load) begin
         shadow_value_r <= bus.value;
         shadow_dp_r    <= bus.dp_in;
      end else begin
         shadow_value_r <= shadow_value_r;
         shadow_dp_r    <= shadow_dp_r;
      end
   end

   // A digit is a leading zero when it and every more-significant nibble are zero.
   always_comb begin
      blank_s    = '0;
      zero_run_s = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run_s = zero_run_s && (shadow_value_r[4*k +: 4] == 4'h0);
         blank_s[k] = bus.lz_blank && zero_run_s && (k > 0);
      end
   end

   // Next output pattern for the currently selected digit.
   always_comb begin
      nibble_s     = shadow_value_r[{digit_idx_r, 2'b00} +: 4];
      seg_s        = 7'b1111111;
      dp_s         = 1'b1;
      an_s         = {DIGITS{1'b1}};
      frame_tick_s = (div_cnt_r == DIV_LAST) && (digit_idx_r == DIGIT_LAST);
      if (blank_s[digit_idx_r]) begin
         seg_s = 7'b1111111;
         dp_s  = 1'b1;
         an_s  = {DIGITS{1'b1}};
      end else begin
         seg_s = hex_to_seg(nibble_s);
         dp_s  = ~shadow_dp_r[digit_idx_r];
         if (div_cnt_r < BLANK_END) begin
            an_s = {DIGITS{1'b1}};
         end else begin
            an_s = ~(DIGITS'(1) << digit_idx_r);
         end
      end
   end

   // Output registers driving the board pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_r        <= 7'b1111111;
         dp_r         <= 1'b1;
         an_r         <= {DIGITS{1'b1}};
         frame_tick_r <= 1'b0;
      end else begin
         seg_r        <= seg_s;
         dp_r         <= dp_s;
         an_r         <= an_s;
         frame_tick_r <= frame_tick_s;
      end
   end

   assign bus.seg        = seg_r;
   assign bus.dp         = dp_r;
   assign bus.an         = an_r;
   assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a cycle-count reference model predicts every output cycle,
// a monitor compares the DUT against the queued predictions.
module tb_seg7_scan_driver;
   localparam int DIGITS = 4;
   localparam int RDIV   = 8;
   localparam int BLANK  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   mon_checks = 0;
   logic [12:0] sb_q[$];

   seg7_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: the position in the scan follows from the edge count since reset.
   int          n_edges = 0;
   logic [15:0] m_val = 16'h0000;
   logic [3:0]  m_dp = 4'h0;
   always @(posedge clk) begin
      if (reset) begin
         n_edges = 0;
         m_val   = 16'h0000;
         m_dp    = 4'h0;
      end else begin
         int e, d, pos, hi;
         logic blanked;
         logic [3:0] nib;
         logic [6:0] s;
         logic p;
         logic [3:0] a;
         e   = n_edges;
         d   = (e / RDIV) % DIGITS;
         pos = e % RDIV;
         hi  = 0;
         for (int k = 0; k < DIGITS; k++)
            if (m_val[4*k +: 4] != 4'h0) hi = k;
         blanked = bus.lz_blank && (d > hi);
         nib = m_val[4*d +: 4];
         s = blanked ? 7'b1111111 : seg_tbl[nib];
         p = blanked ? 1'b1 : ~m_dp[d];
         a = (blanked || pos < BLANK) ? 4'b1111 : ~(4'b0001 << d);
         sb_q.push_back({s, p, a, ((e % (RDIV*DIGITS)) == RDIV*DIGITS-1) ? 1'b1 : 1'b0});
         if (bus.load) begin
            m_val = bus.value;
            m_dp  = bus.dp_in;
         end
         n_edges++;
      end
   end

   // Monitor: outputs are presented every cycle; compare away from the active edge.
   always @(negedge clk) begin
      if (!reset && sb_q.size() > 0) begin
         logic [12:0] exp_v, act_v;
         exp_v = sb_q.pop_front();
         act_v = {bus.seg, bus.dp, bus.an, bus.frame_tick};
         total++;
         mon_checks++;
         if (act_v !== exp_v) begin
            bad++;
            $display("FAIL scan t=%0t seg/dp/an/tick got %b_%b_%b_%b want %b_%b_%b_%b", $time,
                     act_v[12:6], act_v[5], act_v[4:1], act_v[0],
                     exp_v[12:6], exp_v[5], exp_v[4:1], exp_v[0]);
         end
      end
   end

   task automatic check_reset_vals(input string name);
      total++;
      if ({bus.seg, bus.dp, bus.an, bus.frame_tick} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
         bad++;
         $display("FAIL %s got %b_%b_%b_%b want 1111111_1_1111_0", name,
                  bus.seg, bus.dp, bus.an, bus.frame_tick);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
      @(negedge clk);
      bus.value    = v;
      bus.dp_in    = d;
      bus.lz_blank = lz;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
      bus.value    = 16'($urandom);
      bus.dp_in    = 4'($urandom);
   endtask

   task automatic run(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      logic [15:0] sweep [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      bus.value = 16'h0; bus.dp_in = 4'h0; bus.load = 1'b0; bus.lz_blank = 1'b0;
      #12;
      check_reset_vals("reset_state");
      @(negedge clk);
      reset = 1'b0;

      do_load(16'h0001, 4'h0, 1'b0);
      run(40);
      foreach (sweep[i]) begin
         do_load(sweep[i], 4'($urandom), 1'b0);
         run(32);
      end
      run(96);
      do_load(16'h0040, 4'b1000, 1'b1);
      run(32);
      do_load(16'h0000, 4'b1111, 1'b1);
      run(32);
      do_load(16'($urandom), 4'b0101, 1'b0);
      run(32);
      repeat (30) begin
         do_load(16'($urandom) & {4{($urandom_range(0, 1) == 1) ? 4'hF : 4'h0}},
                 4'($urandom), 1'($urandom));
         run($urandom_range(0, 20));
      end
      do_load(16'h1111, 4'h0, 1'b0);
      run(13);

      @(posedge clk);
      #3;
      reset = 1'b1;
      sb_q.delete();
      #1;
      check_reset_vals("reset_mid_slot");
      run(3);
      check_reset_vals("reset_held");
      reset = 1'b0;
      do_load(16'hA5C3, 4'b0011, 1'b0);
      run(40);

      @(negedge clk);
      total++;
      if (mon_checks < 800) begin
         bad++;
         $display("FAIL monitor_activity got %0d checks want >= 800", mon_checks);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display, such as the Basys3 4-digit display. It latches an N-nibble hex value and decodes each nibble to the team's active-low segment pattern. It scans the digits with a programmable refresh divider and adds per-digit decimal points, leading-zero blanking and an anti-ghosting blank interval. It sits between arithmetic result logic (e.g. adders) and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clock cycles each digit stays selected (100 MHz -> 1 kHz per digit); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each digit slot with all anodes off; must be < REFRESH_DIV

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
value  input  4*DIGITS  hex value; nibble k drives digit k (digit 0 = rightmost)
load  input  1  one-cycle strobe; latches value and dp_in into shadow registers
dp_in  input  DIGITS  decimal point enable per digit, 1 = lit
lz_blank  input  1  1 = blank leading zero digits
seg  output  7  segment pattern {a,b,c,d,e,f,g}, seg[6]=a, active-low
dp  output  1  decimal point, active-low
an  output  DIGITS  anode enables, active-low, one-hot-low when active
frame_tick  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0

Behaviour:
- Reset is asynchronous and active-high. It is applied regardless of clk.
- Reset values:
  - div_cnt=0, digit_idx=0, shadow value=0, shadow dp=0.
  - seg=7'b1111111, dp=1, an=all ones, frame_tick=0.
- Shadow registers:
  - On the rising edge with load=1, value and dp_in are captured.
  - The display always shows the shadow registers, never the live inputs.
  - A load mid-scan does not restart the scan. The new data appears from the next output register update.
- Refresh counter:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and digit_idx advances by 1.
  - digit_idx wraps DIGITS-1 -> 0. On that wrap, frame_tick=1 for exactly one cycle.
- Decode, hex nibble -> seg:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Leading-zero blanking, when lz_blank=1:
  - Digit k is blanked when shadow nibbles k..DIGITS-1 are all zero and k>0. Digit 0 is never blanked.
  - A blanked digit drives seg=1111111, dp=1 and an bit k high.
  - The dp of a blanked digit is suppressed even if its dp_in bit is set.
- Anti-ghosting: while div_cnt < BLANK_CYCLES, an=all ones. seg and dp still carry the selected digit's pattern.
- Active slot: an[digit_idx]=0 and all other bits are 1. seg = decode(nibble[digit_idx]); dp = ~shadow_dp[digit_idx].
- Latency: seg, dp, an and frame_tick are registered. Each reflects the div_cnt, digit_idx and shadow state of the previous cycle, so the latency is 1 cycle.
  - After load, the new pattern appears at the outputs 2 edges later (capture edge plus output edge).
- Simultaneous events: load coinciding with a digit advance captures the new data, and the advanced digit shows it on the following cycle.
- Reset mid-scan: everything returns immediately to the reset values. Scanning resumes at digit 0 with div_cnt=0 after reset deasserts.
- DIGITS=1: an is 1 bit. frame_tick pulses every REFRESH_DIV cycles.

Test Plan:
1. Reset and first slot (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2): reset -> seg=1111111, an=1111, dp=1. Release, load value=16'h0001 -> digit 0 shows seg=1001111, an=1110 from the div_cnt=2 slot; an=1111 during div_cnt 0..1.
2. Full hex sweep: load each of 16'h0123, 16'h4567, 16'h89AB and 16'hCDEF, then scan one frame each -> every digit matches the decode table (e.g. digit 3 of 16'hCDEF gives seg=0110001 with an=0111).
3. Scan order and frame_tick: free-run 3 frames -> an active sequence 1110, 1101, 1011, 0111 repeating. frame_tick pulses once per 32 cycles, aligned to the 3->0 wrap.
4. Leading-zero blanking: lz_blank=1, value=16'h0040, dp_in=4'b1000 -> digits 3 and 2 blanked (an stays high, dp suppressed). Digit 1 shows 4 (1001100) and digit 0 shows 0 (0000001). With value=16'h0000, only digit 0 is lit.
5. Mid-scan load and reset: load 16'h1111 while digit 2 is active -> digit 2 shows 1 starting 2 edges after load with no scan restart. Assert reset mid-slot -> outputs go to reset values without a clock edge.
6. Decimal point: dp_in=4'b0101, lz_blank=0 -> dp=0 only while digits 0 and 2 are active.
